sipo_deserializer: RTL and testbench



---
 rtl/sipo_pkg.sv | 13 +
 rtl/sipo_deserializer_if.sv | 31 +++
 rtl/sipo_bit_counter.sv | 46 ++++
 rtl/sipo_deserializer.sv | 108 ++++++++++
 tb/tb_sipo_deserializer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in parallel-out receiver.
package sipo_pkg;

  // Default word width of the link.
  localparam int SIPO_W = 4;

  // Output holding register: empty, or holding an unconsumed word.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and parallel output bundle of the deserializer.
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high; out_valid/out_data are stable until then.
interface sipo_deserializer_if import sipo_pkg::*; #(
  parameter int N = SIPO_W
) ();

  logic         ser_in;
  logic         ser_en;
  logic         frame_sync;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;
  logic         ovr_sticky;
  logic         ovr_clr;

  // Producer of serial bits and consumer of words.
  modport master (
    output ser_in, ser_en, frame_sync, out_ready, ovr_clr,
    input  out_data, out_valid, busy, overrun, ovr_sticky
  );

  // The deserializer itself.
  modport slave (
    input  ser_in, ser_en, frame_sync, out_ready, ovr_clr,
    output out_data, out_valid, busy, overrun, ovr_sticky
  );

endinterface

// File: rtl/sipo_bit_counter.sv
// Bit position counter: counts accepted serial bits, wraps after N-1,
// and can be restarted at 0 (or 1 if a bit is accepted in the same cycle).
module sipo_bit_counter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync_clr,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 tc,
  output logic                 busy
);

  localparam int CW = $clog2(N);

  logic [CW-1:0] cnt_d, cnt_q;
  logic          busy_d, busy_q;

  assign tc   = (cnt_q == CW'(N - 1));
  assign cnt  = cnt_q;
  assign busy = busy_q;

  // Next count: restart has priority, otherwise count accepted bits.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = en ? CW'(1) : '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
    busy_d = (cnt_d != '0);
  end

  // Counter and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver: collects LSB-first bits into N-bit
// words and presents them on a one-deep valid/ready output register.
module sipo_deserializer import sipo_pkg::*; #(
  parameter int N = SIPO_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sipo_deserializer_if.slave    bus,
  output state_e                dbg_state
);

  localparam int CW = $clog2(N);

  // Only the N-1 most recent bits are stored: the Nth bit of a word is
  // taken straight from ser_in in its completion cycle.
  logic [N-2:0]  sr_d, sr_q;
  logic [N-1:0]  data_d, data_q;
  logic [N-1:0]  cand_word;
  logic          ovr_d, ovr_q;
  logic          sticky_d, sticky_q;
  state_e        state_d, state_q;
  logic [CW-1:0] bit_cnt;
  logic          last_bit;
  logic          cnt_busy;
  logic          complete;

  sipo_bit_counter #(.N(N)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.ser_en),
    .sync_clr (bus.frame_sync),
    .cnt      (bit_cnt),
    .tc       (last_bit),
    .busy     (cnt_busy)
  );

  assign cand_word = {bus.ser_in, sr_q};
  // A resync in the completion cycle aborts the word.
  assign complete  = bus.ser_en && last_bit && !bus.frame_sync;

  // Shift register and output FSM next-state logic.
  always_comb begin
    sr_d     = sr_q;
    data_d   = data_q;
    state_d  = state_q;
    ovr_d    = 1'b0;
    sticky_d = sticky_q;

    if (bus.ser_en) begin
      sr_d = cand_word[N-1:1];
    end

    case (state_q)
      EMPTY: begin
        if (complete) begin
          data_d  = cand_word;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete && bus.out_ready) begin
          data_d = cand_word;
        end else if (complete) begin
          ovr_d = 1'b1;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A new overrun wins over a simultaneous clear.
    if (ovr_d) begin
      sticky_d = 1'b1;
    end else if (bus.ovr_clr) begin
      sticky_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      data_q   <= '0;
      state_q  <= EMPTY;
      ovr_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      data_q   <= data_d;
      state_q  <= state_d;
      ovr_q    <= ovr_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_valid  = (state_q == FULL);
  assign bus.busy       = cnt_busy;
  assign bus.overrun    = ovr_q;
  assign bus.ovr_sticky = sticky_q;
  assign dbg_state      = state_q;

  // bit_cnt is only consumed through the counter's tc/busy outputs.
  logic unused_cnt;
  assign unused_cnt = ^bit_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer (N = 4): directed vector table, hand
// sequences for reset corners, and randomized traffic against a model.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sipo_deserializer_if #(.N(N)) bus();
  state_e dbg_state;

  sipo_deserializer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic si, input logic en, input logic fs,
                       input logic rdy, input logic clr);
    bus.ser_in     = si;
    bus.ser_en     = en;
    bus.frame_sync = fs;
    bus.out_ready  = rdy;
    bus.ovr_clr    = clr;
  endtask

  // Advance one cycle; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic [N-1:0] ed,
                            input logic eb, input logic eo, input logic es);
    check({tag, " out_valid"},  16'(bus.out_valid),  16'(ev));
    check({tag, " out_data"},   16'(bus.out_data),   16'(ed));
    check({tag, " busy"},       16'(bus.busy),       16'(eb));
    check({tag, " overrun"},    16'(bus.overrun),    16'(eo));
    check({tag, " ovr_sticky"}, 16'(bus.ovr_sticky), 16'(es));
  endtask

  // ---------------- reference model + scoreboard ----------------
  int           m_cnt;
  logic [N-1:0] m_acc;
  logic [N-1:0] m_data;
  logic         m_valid, m_ovr, m_sticky;
  logic [N-1:0] exp_q[$];

  function automatic void model_reset();
    m_cnt = 0; m_acc = '0; m_data = '0;
    m_valid = 1'b0; m_ovr = 1'b0; m_sticky = 1'b0;
    exp_q.delete();
  endfunction

  // Bits are counted and placed by index; a word is delivered when the
  // Nth bit arrives, unless a resync arrives with it.
  function automatic void model_step(input logic si, input logic en, input logic fs,
                                     input logic rdy, input logic clr);
    bit           done = 1'b0;
    logic [N-1:0] word = '0;
    if (fs) begin
      m_cnt = 0; m_acc = '0;
      if (en) begin m_acc[0] = si; m_cnt = 1; end
    end else if (en) begin
      m_acc[m_cnt] = si;
      m_cnt++;
      if (m_cnt == N) begin
        done = 1'b1; word = m_acc; m_acc = '0; m_cnt = 0;
      end
    end
    m_ovr = 1'b0;
    if (done) begin
      if (!m_valid || rdy) begin
        m_data = word; m_valid = 1'b1; exp_q.push_back(word);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (m_ovr) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic si, en, fs, rdy, clr;
    logic ev; logic [N-1:0] ed; logic eb, eo, es;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic si, input logic en, input logic fs, input logic rdy,
                              input logic clr, input logic ev, input logic [N-1:0] ed,
                              input logic eb, input logic eo, input logic es);
    vec_t v;
    v.si = si; v.en = en; v.fs = fs; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo; v.es = es;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    // Reset then idle.
    do_reset();
    tick();
    check_outs("reset", 0, 4'h0, 0, 0, 0);
    check("reset dbg_state", 16'(dbg_state), 16'(EMPTY));

    //    si en fs rdy clr | valid data busy ovr sticky
    // basic word 1,0,1,1 -> 0xD
    add(1, 1, 0, 0, 0,   0, 4'h0, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'h0, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h0, 1, 0, 0);
    add(1, 1, 0, 0, 0,   1, 4'hD, 0, 0, 0);
    // back-to-back 0,1,0,1 -> 0xA, ready on the completing bit
    add(0, 1, 0, 0, 0,   1, 4'hD, 1, 0, 0);
    add(1, 1, 0, 0, 0,   1, 4'hD, 1, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'hD, 1, 0, 0);
    add(1, 1, 0, 1, 0,   1, 4'hA, 0, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'hA, 0, 0, 0);
    // overrun: 0x3 then 0xC with no ready
    add(1, 1, 0, 0, 0,   0, 4'hA, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'hA, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'hA, 1, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h3, 0, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h3, 1, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h3, 1, 0, 0);
    add(1, 1, 0, 0, 0,   1, 4'h3, 1, 0, 0);
    add(1, 1, 0, 0, 0,   1, 4'h3, 0, 1, 1);
    add(0, 0, 0, 0, 0,   1, 4'h3, 0, 0, 1);
    add(0, 0, 0, 0, 1,   1, 4'h3, 0, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'h3, 0, 0, 0);
    // frame resync: 1,1 | fs+0 | 1,1,0 -> 0x6
    add(1, 1, 0, 0, 0,   0, 4'h3, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h3, 1, 0, 0);
    add(0, 1, 1, 0, 0,   0, 4'h3, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h3, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h3, 1, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h6, 0, 0, 0);
    add(0, 0, 0, 1, 0,   0, 4'h6, 0, 0, 0);
    // frame_sync without ser_en clears a 3-bit partial word
    add(1, 1, 0, 0, 0,   0, 4'h6, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h6, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h6, 1, 0, 0);
    add(1, 0, 1, 0, 0,   0, 4'h6, 0, 0, 0);
    // word 0x1, then 0x2 overruns while ovr_clr is high: set wins
    add(1, 1, 0, 0, 0,   0, 4'h6, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'h6, 1, 0, 0);
    add(0, 1, 0, 0, 0,   0, 4'h6, 1, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h1, 1, 0, 0);
    add(1, 1, 0, 0, 0,   1, 4'h1, 1, 0, 0);
    add(0, 1, 0, 0, 0,   1, 4'h1, 1, 0, 0);
    add(0, 1, 0, 0, 1,   1, 4'h1, 0, 1, 1);
    add(0, 0, 0, 1, 0,   0, 4'h1, 0, 0, 1);
    add(0, 0, 0, 0, 1,   0, 4'h1, 0, 0, 0);
    // completion aborted by frame_sync: no load even though EMPTY
    add(1, 1, 0, 0, 0,   0, 4'h1, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h1, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 4'h1, 1, 0, 0);
    add(1, 1, 1, 0, 0,   0, 4'h1, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].si, vecs[i].en, vecs[i].fs, vecs[i].rdy, vecs[i].clr);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eb,
                 vecs[i].eo, vecs[i].es);
    end

    // Async reset mid-word with a held word.
    do_reset();
    begin
      logic [3:0] w5;
      w5 = 4'h5;
      for (int b = 0; b < 4; b++) begin
        drive(w5[b], 1, 0, 0, 0);
        tick();
      end
    end
    check("pre-reset out_valid", 16'(bus.out_valid), 16'd1);
    check("pre-reset out_data", 16'(bus.out_data), 16'h5);
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0); tick();
    check("pre-reset busy", 16'(bus.busy), 16'd1);
    drive(0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check_outs("async reset", 0, 4'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int b = 0; b < 4; b++) begin
      drive(1, 1, 0, 0, 0);
      tick();
    end
    check_outs("after reset 0xF", 1, 4'hF, 0, 0, 0);

    // Randomized traffic against the model, with a handshake scoreboard.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic si, en, fs, rdy, clr;
      logic [N-1:0] exp_w;
      si  = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      fs  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 9) == 0);
      if (bus.out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rand%0d handshake with no expected word", c), 16'd1, 16'd0);
        end else begin
          exp_w = exp_q.pop_front();
          check($sformatf("rand%0d accepted word", c), 16'(bus.out_data), 16'(exp_w));
        end
      end
      drive(si, en, fs, rdy, clr);
      tick();
      model_step(si, en, fs, rdy, clr);
      check_outs($sformatf("rand%0d", c), m_valid, m_data, (m_cnt != 0), m_ovr, m_sticky);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
